// File: rtl/down_counter_reload_if.sv
// down_counter_reload_if
//   Groups the command and status signals of the down-counting reload timer.
//   The master drives the commands and configuration, and the slave (the timer)
//   drives the count and status back.
//   Commands : ena, srst, start, stop, mode, psc, reload_data, reload_wr, tc_clr
//   Status   : dout, running, tc, tc_flag
interface down_counter_reload_if #(
  parameter int WIDTH     = 16,
  parameter int PSC_WIDTH = 8
);
  logic                 ena;
  logic                 srst;
  logic                 start;
  logic                 stop;
  logic                 mode;
  logic [PSC_WIDTH-1:0] psc;
  logic [WIDTH-1:0]     reload_data;
  logic                 reload_wr;
  logic                 tc_clr;
  logic [WIDTH-1:0]     dout;
  logic                 running;
  logic                 tc;
  logic                 tc_flag;

  modport master (
    output ena, srst, start, stop, mode, psc, reload_data, reload_wr, tc_clr,
    input  dout, running, tc, tc_flag
  );

  modport slave (
    input  ena, srst, start, stop, mode, psc, reload_data, reload_wr, tc_clr,
    output dout, running, tc, tc_flag
  );
endinterface

// File: rtl/down_counter_reload.sv
// down_counter_reload
//   Programmable down-counting timer with a prescaler, a shadow reload
//   register and one-shot or periodic operation. Each prescaler tick
//   decrements the count. A tick that finds the count already at zero is the
//   terminal event. It pulses tc for one clock, sets the sticky tc_flag, and
//   then either reloads the count (periodic mode) or returns to idle (one-shot
//   mode).
//   Ports:
//     clk_i  : system clock, rising edge
//     rst_ni : asynchronous active-low reset
//     bus    : slave side of down_counter_reload_if (commands in, status out)
module down_counter_reload #(
  parameter int WIDTH     = 16,
  parameter int PSC_WIDTH = 8
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  down_counter_reload_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [WIDTH-1:0]     DOUT_ONE = WIDTH'(1);
  localparam logic [PSC_WIDTH-1:0] PCNT_ONE = PSC_WIDTH'(1);

  state_e               state_q;
  logic [WIDTH-1:0]     dout_q;
  logic [WIDTH-1:0]     shadow_q;
  logic [PSC_WIDTH-1:0] pcnt_q;
  logic                 tc_q;
  logic                 flag_q;

  logic [WIDTH-1:0]     reloadVal;
  logic                 tick;

  // The reload value is written through. A write in the same cycle as a start
  // or a periodic reload is used at once, without waiting for the shadow
  // register to update.
  always_comb begin
    reloadVal = bus.reload_wr ? bus.reload_data : shadow_q;
    tick      = (state_q == RUN) && bus.ena && (pcnt_q == bus.psc);
  end

  // Single state/count register block. The tc pulse defaults low, so it lasts
  // exactly one clock. A clear of tc_flag is applied first so that a terminal
  // event in the same cycle sets it again (the set wins). The commands are
  // decoded in priority order: srst, then stop (RUN only), then start, then
  // tick. pcnt is compared with the live psc value. If psc is lowered below
  // the current pcnt, pcnt keeps counting and wraps before it matches.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      dout_q   <= '0;
      shadow_q <= '0;
      pcnt_q   <= '0;
      tc_q     <= 1'b0;
      flag_q   <= 1'b0;
    end else begin
      tc_q <= 1'b0;
      if (bus.reload_wr) begin
        shadow_q <= bus.reload_data;
      end
      if (bus.tc_clr) begin
        flag_q <= 1'b0;
      end

      if (bus.srst) begin
        state_q <= IDLE;
        dout_q  <= '0;
        pcnt_q  <= '0;
        flag_q  <= 1'b0;
      end else if (bus.stop && (state_q == RUN)) begin
        state_q <= IDLE;
        pcnt_q  <= '0;
      end else if (bus.start) begin
        state_q <= RUN;
        dout_q  <= reloadVal;
        pcnt_q  <= '0;
      end else if (tick) begin
        pcnt_q <= '0;
        if (dout_q != '0) begin
          dout_q <= dout_q - DOUT_ONE;
        end else begin
          tc_q   <= 1'b1;
          flag_q <= 1'b1;
          if (bus.mode) begin
            dout_q <= reloadVal;
          end else begin
            state_q <= IDLE;
          end
        end
      end else if ((state_q == RUN) && bus.ena) begin
        pcnt_q <= pcnt_q + PCNT_ONE;
      end
    end
  end

  assign bus.dout    = dout_q;
  assign bus.running = (state_q == RUN);
  assign bus.tc      = tc_q;
  assign bus.tc_flag = flag_q;

endmodule

// File: tb/tb_down_counter_reload.sv
// tb_down_counter_reload
//   Self-checking bench for down_counter_reload. Expected outputs are pushed
//   to a scoreboard queue when stimulus is set up for an edge. They are popped
//   and compared once the DUT has responded, 1 ns after that edge.
module tb_down_counter_reload;

  localparam int WIDTH     = 16;
  localparam int PSC_WIDTH = 8;

  typedef struct {
    string tag;
    int    sel;
    int    exp;
  } expect_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  expect_t sbQueue[$];

  down_counter_reload_if #(.WIDTH(WIDTH), .PSC_WIDTH(PSC_WIDTH)) busIf ();

  down_counter_reload #(.WIDTH(WIDTH), .PSC_WIDTH(PSC_WIDTH)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (busIf)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counts one comparison and reports it if it does not match.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Queues expected outputs. A negative value means that output is not checked.
  task automatic pushExpect(input string tag, input int d, input int r, input int t, input int f);
    if (d >= 0) sbQueue.push_back('{tag: {tag, ".dout"},    sel: 0, exp: d});
    if (r >= 0) sbQueue.push_back('{tag: {tag, ".running"}, sel: 1, exp: r});
    if (t >= 0) sbQueue.push_back('{tag: {tag, ".tc"},      sel: 2, exp: t});
    if (f >= 0) sbQueue.push_back('{tag: {tag, ".tc_flag"}, sel: 3, exp: f});
  endtask

  // Pops every pending expectation and compares it with the live DUT outputs.
  task automatic drainScoreboard();
    expect_t e;
    int      obs;
    while (sbQueue.size() > 0) begin
      e = sbQueue.pop_front();
      case (e.sel)
        0:       obs = int'(busIf.dout);
        1:       obs = int'(busIf.running);
        2:       obs = int'(busIf.tc);
        default: obs = int'(busIf.tc_flag);
      endcase
      checkOutput(e.tag, obs, e.exp);
    end
  endtask

  // Lets the DUT take one clock edge with the current inputs, then checks
  // the results away from the edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    drainScoreboard();
  endtask

  task automatic clearPulses();
    busIf.start     = 1'b0;
    busIf.stop      = 1'b0;
    busIf.srst      = 1'b0;
    busIf.reload_wr = 1'b0;
    busIf.tc_clr    = 1'b0;
  endtask

  initial begin
    int d;
    int t;
    int cp;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    busIf.ena         = 1'b1;
    busIf.mode        = 1'b0;
    busIf.psc         = '0;
    busIf.reload_data = '0;
    clearPulses();

    // Reset state, checked both before and after clock edges.
    #1;
    pushExpect("reset", 0, 0, 0, 0);
    drainScoreboard();
    pushExpect("reset held", 0, 0, 0, 0);
    applyStimulus();
    rst_n = 1'b1;
    pushExpect("reset released", 0, 0, 0, 0);
    applyStimulus();

    // One-shot R=3, psc=0, using a write-through reload at start.
    busIf.mode = 1'b0;
    busIf.reload_data = 16'd3;
    busIf.reload_wr = 1'b1;
    busIf.start = 1'b1;
    pushExpect("oneshot start", 3, 1, 0, 0);
    applyStimulus();
    clearPulses();
    for (int c = 1; c <= 6; c++) begin
      if (c <= 3)      pushExpect($sformatf("oneshot c%0d", c), 3 - c, 1, 0, 0);
      else if (c == 4) pushExpect($sformatf("oneshot c%0d", c), 0, 0, 1, 1);
      else             pushExpect($sformatf("oneshot c%0d", c), 0, 0, 0, 1);
      applyStimulus();
    end
    busIf.tc_clr = 1'b1;
    pushExpect("oneshot tc_clr", 0, 0, 0, 0);
    applyStimulus();
    clearPulses();

    // Periodic R=4, psc=2. The period is 15 clocks. tc_clr on the terminal
    // edge loses to the set; tc_clr one clock later clears the flag.
    busIf.mode = 1'b1;
    busIf.psc = 8'd2;
    busIf.reload_data = 16'd4;
    busIf.reload_wr = 1'b1;
    pushExpect("periodic shadow wr idle", 0, 0, 0, 0);
    applyStimulus();
    clearPulses();
    busIf.start = 1'b1;
    pushExpect("periodic start", 4, 1, 0, 0);
    applyStimulus();
    clearPulses();
    for (int c = 1; c <= 60; c++) begin
      busIf.tc_clr = (c == 30 || c == 31);
      pushExpect($sformatf("periodic c%0d", c), 4 - ((c / 3) % 5), 1,
                 (c % 15 == 0) ? 1 : 0,
                 ((c >= 15 && c <= 30) || c >= 45) ? 1 : 0);
      applyStimulus();
    end
    clearPulses();
    busIf.stop = 1'b1;
    pushExpect("periodic stop", 4, 0, 0, 1);
    applyStimulus();
    clearPulses();

    // Shadow update in the middle of a period: R=5, then write 2 when dout=3.
    busIf.psc = 8'd0;
    busIf.reload_data = 16'd5;
    busIf.reload_wr = 1'b1;
    busIf.start = 1'b1;
    pushExpect("shadow start", 5, 1, 0, 1);
    applyStimulus();
    clearPulses();
    for (int c = 1; c <= 15; c++) begin
      busIf.reload_wr = (c == 3);
      busIf.reload_data = 16'd2;
      if (c < 6) d = 5 - c;
      else       d = (c % 3 == 0) ? 2 : ((c % 3 == 1) ? 1 : 0);
      t = (c >= 6 && c % 3 == 0) ? 1 : 0;
      pushExpect($sformatf("shadow c%0d", c), d, 1, t, 1);
      applyStimulus();
    end
    clearPulses();
    busIf.stop = 1'b1;
    pushExpect("shadow stop", 2, 0, 0, 1);
    applyStimulus();
    clearPulses();

    // Freeze with pcnt mid-count: R=10, psc=1, ena low for 7 edges at dout=8.
    busIf.psc = 8'd1;
    busIf.reload_data = 16'd10;
    busIf.reload_wr = 1'b1;
    busIf.start = 1'b1;
    pushExpect("freeze start", 10, 1, 0, 1);
    applyStimulus();
    clearPulses();
    for (int c = 1; c <= 39; c++) begin
      busIf.ena = !(c >= 6 && c <= 12);
      cp = (c < 6) ? c : c - 7;
      if (c >= 6 && c <= 12) d = 8;
      else if (cp < 22)      d = 10 - cp / 2;
      else                   d = 10 - (cp - 22) / 2;
      t = (cp == 22 && c > 12) ? 1 : 0;
      pushExpect($sformatf("freeze c%0d", c), d, 1, t, 1);
      applyStimulus();
    end
    busIf.ena = 1'b1;
    busIf.stop = 1'b1;
    pushExpect("stop at 5", 5, 0, 0, 1);
    applyStimulus();
    clearPulses();
    for (int c = 0; c < 2; c++) begin
      pushExpect("stopped hold", 5, 0, 0, 1);
      applyStimulus();
    end
    busIf.start = 1'b1;
    pushExpect("restart", 10, 1, 0, 1);
    applyStimulus();
    clearPulses();
    pushExpect("restart pcnt cleared", 10, 1, 0, 1);
    applyStimulus();
    pushExpect("restart first tick", 9, 1, 0, 1);
    applyStimulus();

    // Priority: srst beats start, and the shadow register survives srst.
    busIf.srst = 1'b1;
    busIf.start = 1'b1;
    pushExpect("srst+start", 0, 0, 0, 0);
    applyStimulus();
    clearPulses();
    busIf.psc = 8'd0;
    busIf.start = 1'b1;
    pushExpect("shadow kept", 10, 1, 0, 0);
    applyStimulus();
    clearPulses();
    pushExpect("prio tick", 9, 1, 0, 0);
    applyStimulus();
    busIf.stop = 1'b1;
    busIf.start = 1'b1;
    pushExpect("stop+start", 9, 0, 0, 0);
    applyStimulus();
    clearPulses();
    busIf.stop = 1'b1;
    pushExpect("stop in idle", 9, 0, 0, 0);
    applyStimulus();
    clearPulses();

    // Periodic with reload 0 gives a terminal event on every tick.
    busIf.mode = 1'b1;
    busIf.reload_data = 16'd0;
    busIf.reload_wr = 1'b1;
    busIf.start = 1'b1;
    pushExpect("zero start", 0, 1, 0, 0);
    applyStimulus();
    clearPulses();
    for (int c = 1; c <= 3; c++) begin
      pushExpect($sformatf("zero c%0d", c), 0, 1, 1, 1);
      applyStimulus();
    end
    busIf.ena = 1'b0;
    pushExpect("zero ena low", 0, 1, 0, 1);
    applyStimulus();
    busIf.ena = 1'b1;
    busIf.stop = 1'b1;
    pushExpect("zero stop", 0, 0, 0, 1);
    applyStimulus();
    clearPulses();

    // Asynchronous reset in the middle of a run, at dout=6.
    busIf.reload_data = 16'd10;
    busIf.reload_wr = 1'b1;
    busIf.start = 1'b1;
    pushExpect("async start", 10, 1, 0, 1);
    applyStimulus();
    clearPulses();
    for (int c = 1; c <= 4; c++) begin
      pushExpect($sformatf("async c%0d", c), 10 - c, 1, 0, 1);
      applyStimulus();
    end
    #3;
    rst_n = 1'b0;
    #1;
    pushExpect("async reset", 0, 0, 0, 0);
    drainScoreboard();
    pushExpect("async reset held", 0, 0, 0, 0);
    applyStimulus();
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      pushExpect("post reset idle", 0, 0, 0, 0);
      applyStimulus();
    end
    busIf.start = 1'b1;
    pushExpect("post reset shadow 0", 0, 1, 0, 0);
    applyStimulus();
    clearPulses();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
